// File: rtl/piezo_tone_gen.sv
// Piezo driver: turns a 4-bit note code into a half-period-counted square wave and
// overrides it with a retriggerable two-tone miss buzz.
module piezo_tone_gen #(
    parameter int unsigned MISS_LEN   = 25000000,
    parameter int unsigned TONE_SHIFT = 0          // divides every half-period by 2**TONE_SHIFT (simulation only)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note_code,
    input  logic       play_miss,
    input  logic       mute,
    output logic       piezo_pin,
    output logic       miss_active,
    output logic       note_active
);
    localparam int unsigned HALF_W = 18;
    localparam int unsigned DUR_W  = 25;
    localparam int unsigned CODE_W = 4;

    localparam logic [DUR_W-1:0]  HI_END  = DUR_W'(MISS_LEN / 2 - 1);
    localparam logic [DUR_W-1:0]  LO_END  = DUR_W'(MISS_LEN - 1);
    localparam logic [HALF_W-1:0] HI_HALF = HALF_W'(166667 >> TONE_SHIFT);
    localparam logic [HALF_W-1:0] LO_HALF = HALF_W'(250000 >> TONE_SHIFT);

    typedef enum logic [1:0] {
        ST_NOTE,
        ST_MISS_HI,
        ST_MISS_LO
    } state_t;

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                level_q, level_d;
    logic [CODE_W-1:0]   prev_q, prev_d;
    logic [HALF_W-1:0]   half_per;
    logic [HALF_W-1:0]   step_half;
    logic                step_level;

    // Half-period lookup for note codes; zero marks silence.
    function automatic logic [HALF_W-1:0] note_half(input logic [CODE_W-1:0] code);
        logic [HALF_W-1:0] h;
        case (code)
            4'd1:    h = 18'd95555;
            4'd2:    h = 18'd85132;
            4'd3:    h = 18'd75843;
            4'd4:    h = 18'd71586;
            4'd5:    h = 18'd63776;
            4'd6:    h = 18'd56818;
            4'd7:    h = 18'd50620;
            4'd8:    h = 18'd47778;
            default: h = 18'd0;
        endcase
        return h >> TONE_SHIFT;
    endfunction

    function automatic logic note_valid(input logic [CODE_W-1:0] code);
        return (code != 4'd0) && (code <= 4'd8);
    endfunction

    // Next-state and tone-core logic.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        dur_d      = dur_q;
        level_d    = level_q;
        prev_d     = prev_q;
        half_per   = note_half(prev_q);
        step_half  = half_q + 18'd1;
        step_level = level_q;

        if (state_q == ST_MISS_HI) begin
            half_per = HI_HALF;
        end else if (state_q == ST_MISS_LO) begin
            half_per = LO_HALF;
        end

        // >= lets the counter recover at once if the half-period shrinks below it
        if (half_q >= half_per - 18'd1) begin
            step_half  = '0;
            step_level = ~level_q;
        end

        case (state_q)
            ST_NOTE: begin
                prev_d = note_code;
                if ((note_code != prev_q) || !note_valid(note_code)) begin
                    half_d  = '0;
                    level_d = 1'b0;
                end else begin
                    half_d  = step_half;
                    level_d = step_level;
                end
            end
            ST_MISS_HI: begin
                dur_d = dur_q + 25'd1;
                if (dur_q == HI_END) begin
                    state_d = ST_MISS_LO;
                    half_d  = '0;
                    level_d = 1'b0;
                end else begin
                    half_d  = step_half;
                    level_d = step_level;
                end
            end
            ST_MISS_LO: begin
                dur_d = dur_q + 25'd1;
                if (dur_q == LO_END) begin
                    state_d = ST_NOTE;
                    prev_d  = note_code;
                    dur_d   = '0;
                    half_d  = '0;
                    level_d = 1'b0;
                end else begin
                    half_d  = step_half;
                    level_d = step_level;
                end
            end
            default: begin
                state_d = ST_NOTE;
                half_d  = '0;
                level_d = 1'b0;
            end
        endcase

        // A miss request wins over everything, including a same-cycle note change.
        if (play_miss) begin
            state_d = ST_MISS_HI;
            half_d  = '0;
            dur_d   = '0;
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_NOTE;
            half_q      <= '0;
            dur_q       <= '0;
            level_q     <= 1'b0;
            prev_q      <= '0;
            piezo_pin   <= 1'b0;
            miss_active <= 1'b0;
            note_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            dur_q       <= dur_d;
            level_q     <= level_d;
            prev_q      <= prev_d;
            piezo_pin   <= level_q & ~mute;
            miss_active <= (state_d != ST_NOTE);
            note_active <= (state_d == ST_NOTE) && note_valid(prev_d);
        end
    end

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Bench for piezo_tone_gen: per-cycle comparison against a phase-arithmetic reference,
// a segment table with expected status flags, and hand-timed miss/reset sequences.
module tb_piezo_tone_gen;
    localparam int unsigned MISS_LEN   = 4000;
    localparam int unsigned TONE_SHIFT = 8;
    localparam int          RETRIG     = 2800;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] note_code = 4'd0;
    logic       play_miss = 1'b0;
    logic       mute = 1'b0;
    logic       piezo_pin;
    logic       miss_active;
    logic       note_active;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    piezo_tone_gen #(.MISS_LEN(MISS_LEN), .TONE_SHIFT(TONE_SHIFT)) dut (
        .clk         (clk),
        .reset       (reset),
        .note_code   (note_code),
        .play_miss   (play_miss),
        .mute        (mute),
        .piezo_pin   (piezo_pin),
        .miss_active (miss_active),
        .note_active (note_active)
    );

    always #5 clk = ~clk;

    // Reference: mode 0 = note, 1 = high buzz, 2 = low buzz; m_n = edges since phase start.
    int m_mode = 0;
    int m_n    = 0;
    int m_dur  = 0;
    int m_prev = 0;
    bit m_piezo = 1'b0;
    bit m_miss  = 1'b0;
    bit m_note  = 1'b0;

    function automatic int half_of(int mode, int code);
        int base;
        if (mode == 1)      base = 166667;
        else if (mode == 2) base = 250000;
        else begin
            case (code)
                1: base = 95555;  2: base = 85132;  3: base = 75843;  4: base = 71586;
                5: base = 63776;  6: base = 56818;  7: base = 50620;  8: base = 47778;
                default: base = 0;
            endcase
        end
        return base >> TONE_SHIFT;
    endfunction

    function automatic bit code_ok(int c);
        return (c >= 1) && (c <= 8);
    endfunction

    function automatic bit level_of(int mode, int code, int n);
        int h;
        h = half_of(mode, code);
        if (h == 0) return 1'b0;
        return ((n / h) % 2) == 1;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_n = 0; m_dur = 0; m_prev = 0;
        m_piezo = 1'b0; m_miss = 1'b0; m_note = 1'b0;
    endtask

    task automatic m_step();
        bit lvl;
        int code;
        lvl  = level_of(m_mode, m_prev, m_n);
        code = int'(note_code);
        m_piezo = lvl & ~mute;
        if (play_miss) begin
            m_mode = 1; m_n = 0; m_dur = 0;
        end else if (m_mode == 0) begin
            if (code != m_prev || !code_ok(code)) m_n = 0;
            else m_n++;
            m_prev = code;
        end else begin
            if (m_mode == 1 && m_dur == MISS_LEN / 2 - 1) begin
                m_mode = 2; m_n = 0;
            end else if (m_mode == 2 && m_dur == MISS_LEN - 1) begin
                m_mode = 0; m_n = 0; m_prev = code;
            end else begin
                m_n++;
            end
            m_dur++;
        end
        m_miss = (m_mode != 0);
        m_note = (m_mode == 0) && code_ok(m_prev);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) m_reset();
        else        m_step();
    end

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && reset) begin
            check_bit("piezo_pin", piezo_pin, m_piezo);
            check_bit("miss_active", miss_active, m_miss);
            check_bit("note_active", note_active, m_note);
        end
    end

    typedef struct {
        logic [3:0] code;
        bit         mute;
        bit         miss;
        int         cycles;
        bit         exp_note;
        bit         exp_miss;
    } seg_t;

    seg_t tbl[11];

    initial begin
        int n;
        int h6;
        bit seen_low;

        tbl[0]  = '{4'd6,  1'b0, 1'b0,  350, 1'b1, 1'b0};
        tbl[1]  = '{4'd1,  1'b0, 1'b0,  900, 1'b1, 1'b0};
        tbl[2]  = '{4'd0,  1'b0, 1'b0,  800, 1'b0, 1'b0};
        tbl[3]  = '{4'd12, 1'b0, 1'b0,  800, 1'b0, 1'b0};
        tbl[4]  = '{4'd8,  1'b1, 1'b0,  400, 1'b1, 1'b0};
        tbl[5]  = '{4'd8,  1'b0, 1'b0,  400, 1'b1, 1'b0};
        tbl[6]  = '{4'd3,  1'b0, 1'b1, 1000, 1'b0, 1'b1};
        tbl[7]  = '{4'd5,  1'b0, 1'b0, 3500, 1'b1, 1'b0};
        tbl[8]  = '{4'd9,  1'b0, 1'b0,  300, 1'b0, 1'b0};
        tbl[9]  = '{4'd2,  1'b1, 1'b1,  200, 1'b0, 1'b1};
        tbl[10] = '{4'd2,  1'b0, 1'b0, 4000, 1'b1, 1'b0};

        // Reset state with note 6 already requested.
        note_code = 4'd6;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_piezo", piezo_pin, 1'b0);
        check_bit("rst_miss", miss_active, 1'b0);
        check_bit("rst_note", note_active, 1'b0);
        chk_en = 1'b1;
        reset  = 1'b1;

        // First rise: change edge, H counting edges, one output pipeline edge.
        h6 = 56818 >> TONE_SHIFT;
        n = 0;
        while (piezo_pin !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check_int("first_rise_edges", n, h6 + 2);
        n = 0;
        seen_low = 1'b0;
        while (!(seen_low && piezo_pin === 1'b1) && n < 5000) begin
            @(posedge clk); #1; n++;
            if (piezo_pin === 1'b0) seen_low = 1'b1;
        end
        check_int("note6_period", n, 2 * h6);

        foreach (tbl[i]) begin
            @(negedge clk);
            note_code = tbl[i].code;
            mute      = tbl[i].mute;
            play_miss = tbl[i].miss;
            @(negedge clk);
            play_miss = 1'b0;
            repeat (tbl[i].cycles - 1) @(negedge clk);
            check_bit($sformatf("seg%0d_note_active", i), note_active, tbl[i].exp_note);
            check_bit($sformatf("seg%0d_miss_active", i), miss_active, tbl[i].exp_miss);
        end

        // Random segments checked cycle by cycle against the reference.
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            note_code = 4'($urandom_range(0, 15));
            mute      = ($urandom_range(0, 3) == 0);
            play_miss = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            play_miss = 1'b0;
            repeat ($urandom_range(30, 800)) @(negedge clk);
        end

        // Single miss: exact buzz length.
        @(negedge clk);
        note_code = 4'd3; mute = 1'b0; play_miss = 1'b1;
        @(negedge clk);
        play_miss = 1'b0;
        n = 0;
        while (miss_active === 1'b1 && n < 20000) begin
            n++; @(negedge clk);
        end
        check_int("miss_len", n, MISS_LEN);

        // Retrigger partway into a buzz: miss_active must never drop in between.
        repeat (50) @(negedge clk);
        play_miss = 1'b1;
        @(negedge clk);
        play_miss = 1'b0;
        n = 0;
        while (miss_active === 1'b1 && n < 20000) begin
            play_miss = (n == RETRIG - 1);
            n++; @(negedge clk);
        end
        play_miss = 1'b0;
        check_int("retrigger_len", n, MISS_LEN + RETRIG);

        // Asynchronous reset during the low-tone phase.
        repeat (20) @(negedge clk);
        note_code = 4'd4;
        play_miss = 1'b1;
        @(negedge clk);
        play_miss = 1'b0;
        repeat (MISS_LEN / 2 + 500) @(negedge clk);
        check_bit("pre_rst_miss", miss_active, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_bit("async_rst_piezo", piezo_pin, 1'b0);
        check_bit("async_rst_miss", miss_active, 1'b0);
        check_bit("async_rst_note", note_active, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (1500) @(negedge clk);
        check_bit("post_rst_note", note_active, 1'b1);
        check_bit("post_rst_miss", miss_active, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
